// File: rtl/bitstream_pkg.sv
// Shared types and constants for the bitstream packer.
//   state_e        : packer FSM states
//   MAX_CODE_BITS  : widest code beat the packer can absorb in one cycle
//   N_W            : width of a clamped code length (0..MAX_CODE_BITS)
//   clog2_fill     : width of a fill counter able to hold 0..buf_w
package bitstream_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned MAX_CODE_BITS = 64;
  localparam int unsigned N_W           = 7;

  function automatic int unsigned clog2_fill(input int unsigned buf_w);
    return $clog2(buf_w + 1);
  endfunction

endpackage

// File: rtl/bit_append_shifter.sv
// Combinational buffer datapath: optionally retires the oldest OUT_W bits,
// then appends the low n_i bits of val_i directly behind the surviving bits.
//   buf_i/fill_i      : current buffer (oldest bit at MSB) and its fill level
//   val_i/n_i         : code value and clamped length (0..64)
//   shift_out_i       : a word leaves the buffer this cycle
//   buf_o/fill_o      : next buffer and fill
module bit_append_shifter
  import bitstream_pkg::*;
#(
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned BUF_W  = 128,
  parameter int unsigned FILL_W = clog2_fill(BUF_W)
) (
  input  logic [BUF_W-1:0]         buf_i,
  input  logic [FILL_W-1:0]        fill_i,
  input  logic [MAX_CODE_BITS-1:0] val_i,
  input  logic [N_W-1:0]           n_i,
  input  logic                     shift_out_i,
  output logic [BUF_W-1:0]         buf_o,
  output logic [FILL_W-1:0]        fill_o
);

  logic [BUF_W-1:0]         shifted;
  logic [FILL_W-1:0]        fill_s;
  logic [MAX_CODE_BITS-1:0] mask;
  logic [MAX_CODE_BITS-1:0] code;
  int unsigned              pos;

  // Bits below fill are always zero, so the new code can simply be OR-ed in.
  always_comb begin
    shifted = shift_out_i ? (buf_i << OUT_W) : buf_i;
    fill_s  = shift_out_i ? (fill_i - FILL_W'(OUT_W)) : fill_i;
    mask    = (n_i >= N_W'(MAX_CODE_BITS)) ? '1
            : ((MAX_CODE_BITS'(1) << n_i) - MAX_CODE_BITS'(1));
    code    = val_i & mask;
    pos     = BUF_W - 32'(fill_s) - 32'(n_i);
    buf_o   = shifted | (BUF_W'(code) << pos);
    fill_o  = fill_s + FILL_W'(n_i);
  end

endmodule

// File: rtl/bitstream_packer.sv
// Packs variable-length code beats MSB-first into OUT_W-bit words; on flush
// zero-pads to a word boundary, drains, tags the final word and pulses done.
//   clock/reset            : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      : code beat handshake (val, size_of_bit, flush_bit)
//   out_valid/out_ready    : output word handshake (out_data, out_last)
//   flush_done             : one-cycle pulse after a flush has drained
//   bit_count              : code bits accepted since reset (padding excluded)
//   err_size               : sticky, a beat had size_of_bit > 64
module bitstream_packer
  import bitstream_pkg::*;
#(
  parameter int unsigned OUT_W = 32,
  parameter int unsigned BUF_W = 128
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      val,
  input  logic [63:0]      size_of_bit,
  input  logic             flush_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             flush_done,
  output logic [63:0]      bit_count,
  output logic             err_size
);

  localparam int unsigned FILL_W    = clog2_fill(BUF_W);
  localparam int unsigned READY_MAX = BUF_W - MAX_CODE_BITS;

  state_e              state_q, state_d;
  logic [BUF_W-1:0]    buf_q, buf_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                flush_done_q, flush_done_d;
  logic [63:0]         bit_count_q, bit_count_d;
  logic                err_size_q, err_size_d;

  logic                accept, emit, oversize;
  logic [N_W-1:0]      n_eff, n_app;
  logic [BUF_W-1:0]    sh_buf;
  logic [FILL_W-1:0]   sh_fill;
  int unsigned         rem;

  // Handshakes and clamped code length.
  always_comb begin
    oversize = size_of_bit > 64'(MAX_CODE_BITS);
    n_eff    = oversize ? N_W'(MAX_CODE_BITS) : N_W'(size_of_bit);
    accept   = in_valid && in_ready_q;
    emit     = out_valid_q && out_ready;
    n_app    = accept ? n_eff : '0;
  end

  bit_append_shifter #(
    .OUT_W (OUT_W),
    .BUF_W (BUF_W),
    .FILL_W(FILL_W)
  ) u_shifter (
    .buf_i      (buf_q),
    .fill_i     (fill_q),
    .val_i      (val),
    .n_i        (n_app),
    .shift_out_i(emit),
    .buf_o      (sh_buf),
    .fill_o     (sh_fill)
  );

  // Next state; outputs are registered from the post-update state and fill.
  always_comb begin
    state_d     = state_q;
    buf_d       = sh_buf;
    fill_d      = sh_fill;
    bit_count_d = bit_count_q;
    err_size_d  = err_size_q;
    rem         = 0;

    if (accept) begin
      bit_count_d = bit_count_q + 64'(n_eff);
      if (oversize) err_size_d = 1'b1;
    end

    case (state_q)
      RUN: begin
        if (accept && flush_bit) begin
          // Padding bits are already zero; only the fill level moves.
          rem = 32'(sh_fill) % OUT_W;
          if (rem != 0) fill_d = sh_fill + FILL_W'(OUT_W - rem);
          state_d = (fill_d == '0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (emit && (fill_q == FILL_W'(OUT_W))) state_d = DONE;
      end
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase

    in_ready_d   = (state_d == RUN) && (fill_d <= FILL_W'(READY_MAX));
    out_valid_d  = (state_d != DONE) && (fill_d >= FILL_W'(OUT_W));
    out_last_d   = (state_d == DRAIN) && (fill_d == FILL_W'(OUT_W));
    flush_done_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RUN;
      buf_q        <= '0;
      fill_q       <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      flush_done_q <= 1'b0;
      bit_count_q  <= '0;
      err_size_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      fill_q       <= fill_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      flush_done_q <= flush_done_d;
      bit_count_q  <= bit_count_d;
      err_size_q   <= err_size_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = buf_q[BUF_W-1 -: OUT_W];
  assign out_last   = out_last_q;
  assign flush_done = flush_done_q;
  assign bit_count  = bit_count_q;
  assign err_size   = err_size_q;

endmodule
